// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory wrapper: address windows, index
// width, arbiter state encoding and a small range-check helper.
package dmem_pkg;

   // Word index width of the 128-word variable data memory.
   localparam int IDX_W = 7;

   // Byte address window of the variable data memory (inclusive bounds).
   localparam logic [31:0] DVAR_BASE = 32'h0000_0800;
   localparam logic [31:0] DVAR_TOP  = 32'h0000_09FC;

   // Width of the starvation counter; holds any legal limit up to 255.
   localparam int WAIT_W = 8;

   // Arbiter states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2,
      ACK   = 2'd3
   } arb_state_e;

   // True when addr lies inside [base, top].
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
      return (addr >= base) && (addr <= top);
   endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational CPU address decode: flags an access that falls inside a
// memory window and extracts the word index. Shared by the variable and
// constant memory paths through the BASE/TOP parameters.
module dmem_addr_decode
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE = DVAR_BASE,
   parameter logic [31:0] TOP  = DVAR_TOP
) (
   input  logic             re,
   input  logic             we,
   input  logic [31:0]      addr,
   output logic             hit,
   output logic [IDX_W-1:0] idx
);

   assign hit = (re | we) & in_range(addr, BASE, TOP);
   assign idx = addr[IDX_W+1:2];

endmodule

// File: rtl/dmem_var_arbiter.sv
// Write-port arbiter for the variable data memory. The CPU owns the port
// except during the single GRANT cycle of a debug transaction; a debug
// request denied for STARVE_LIMIT cycles is force-granted and the CPU is
// stalled for that cycle. Stall cycles are counted with saturation.
module dmem_var_arbiter
   import dmem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cpu_re,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [6:0]       dbg_addr,
   input  logic [31:0]      dbg_wdata,
   output logic             dbg_ack,
   output logic [31:0]      dbg_rdata,
   output logic [6:0]       mem_addr,
   output logic             mem_we,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

   logic              cpu_hit_s;
   logic [IDX_W-1:0]  cpu_idx_s;
   arb_state_e        state_r;
   arb_state_e        state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_nxt_s;
   logic              dbg_ack_r;
   logic [31:0]       dbg_rdata_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              stall_s;
   logic              mem_we_s;
   logic [IDX_W-1:0]  mem_addr_s;
   logic [31:0]       mem_wdata_s;

   dmem_addr_decode #(
      .BASE (DVAR_BASE),
      .TOP  (DVAR_TOP)
   ) u_decode (
      .re   (cpu_re),
      .we   (cpu_we),
      .addr (cpu_addr),
      .hit  (cpu_hit_s),
      .idx  (cpu_idx_s)
   );

   // Next-state logic and memory port mux; CPU drives the port outside GRANT.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      mem_addr_s     = cpu_idx_s;
      mem_we_s       = cpu_we & cpu_hit_s;
      mem_wdata_s    = cpu_wdata;
      stall_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (dbg_req) begin
               if (cpu_hit_s) begin
                  state_nxt_s    = WAIT;
                  wait_cnt_nxt_s = WAIT_W'(1);
               end else begin
                  state_nxt_s = GRANT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            if (!cpu_hit_s || (wait_cnt_r == LIMIT_C)) begin
               state_nxt_s = GRANT;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
            end
         end
         GRANT: begin
            mem_addr_s  = dbg_addr;
            mem_we_s    = dbg_we;
            mem_wdata_s = dbg_wdata;
            stall_s     = cpu_hit_s;
            state_nxt_s = ACK;
         end
         ACK: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // While RESET is high nothing is written and the CPU is never stalled.
   assign mem_we    = mem_we_s & ~RESET;
   assign cpu_stall = stall_s & ~RESET;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;
   assign cpu_rdata = mem_rdata;
   assign dbg_ack   = dbg_ack_r;
   assign dbg_rdata = dbg_rdata_r;
   assign stall_cnt = stall_cnt_r;

   // State register and starvation counter.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r    <= IDLE;
         wait_cnt_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Debug completion pulse and read-before-write capture during GRANT.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dbg_ack_r   <= 1'b0;
         dbg_rdata_r <= 32'h0000_0000;
      end else begin
         dbg_ack_r <= (state_r == GRANT);
         if (state_r == GRANT) begin
            dbg_rdata_r <= mem_rdata;
         end else begin
            dbg_rdata_r <= dbg_rdata_r;
         end
      end
   end

   // Saturating count of CPU stall cycles.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cnt_r <= '0;
      end else if (cpu_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: doc/dmem_var_arbiter.md
# dmem_var_arbiter

Arbitrates the single write port of the 128-word variable data memory (byte range 0x800–0x9FC) between the ARM core and a debug/loader port. It sits in the wrapper between the core's `MemWrite`/`ALUResult`/`WriteData` signals and the memory array. The CPU has priority. A pending debug request is force-granted after a bounded number of denied cycles, and the CPU is stalled for that one cycle. A saturating counter records the number of CPU stall cycles.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive denied cycles for a pending debug request before a forced grant. Legal range 1–255.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `CLK`  in  1: clock. All state changes on the rising edge.
- `RESET`  in  1: reset, asynchronous, active-high.
- `cpu_re`  in  1: CPU load in the current cycle.
- `cpu_we`  in  1: CPU store in the current cycle (`MemWrite`).
- `cpu_addr`  in  32: CPU byte address (`ALUResult`).
- `cpu_wdata`  in  32: CPU store data.
- `cpu_rdata`  out  32: CPU load data. Combinational, equal to `mem_rdata`.
- `cpu_stall`  out  1: CPU must hold PC and all state this cycle.
- `dbg_req`  in  1: debug request. Held high until `dbg_ack`.
- `dbg_we`  in  1: debug write. Stable while `dbg_req` is high.
- `dbg_addr`  in  7: debug word index. Stable while `dbg_req` is high.
- `dbg_wdata`  in  32: debug write data. Stable while `dbg_req` is high.
- `dbg_ack`  out  1: one-cycle completion pulse.
- `dbg_rdata`  out  32: registered debug read data. Valid while `dbg_ack` is high, and holds its value afterwards.
- `mem_addr`  out  7: array word index.
- `mem_we`  out  1: array write enable.
- `mem_wdata`  out  32: array write data.
- `mem_rdata`  in  32: array asynchronous read data at `mem_addr`.
- `stall_cnt`  out  `CNT_W`: saturating count of `cpu_stall` cycles.

## Operation
- `cpu_hit = (cpu_re | cpu_we) & (cpu_addr >= 0x800) & (cpu_addr <= 0x9FC)`. The CPU index is `cpu_addr[8:2]`. CPU accesses outside this range never contend.
- States:
  - `IDLE`:
    - If `dbg_req` and not `cpu_hit`, go to `GRANT`.
    - If `dbg_req` and `cpu_hit`, go to `WAIT` and load `wait_cnt` with 1.
  - `WAIT`:
    - If not `cpu_hit`, or `wait_cnt == STARVE_LIMIT`, go to `GRANT`.
    - Otherwise increment `wait_cnt`.
  - `GRANT`:
    - Drive the memory port from the debug inputs; `mem_we = dbg_we`.
    - Capture `dbg_rdata <= mem_rdata` (read-before-write value at the edge).
    - `cpu_stall = cpu_hit`.
    - Go to `ACK`.
  - `ACK`: `dbg_ack = 1`, then go to `IDLE`. A `dbg_req` still high in the next `IDLE` cycle is treated as a new transaction.
- Memory port mux:
  - In every state other than `GRANT`, the port carries the CPU access: `mem_addr = cpu_addr[8:2]`, `mem_we = cpu_we & cpu_hit`.
  - In `GRANT`, the CPU access is suppressed (no write) and stalled.
- `stall_cnt` increments on every cycle with `cpu_stall = 1` and saturates at all-ones.

## Timing
- Reset values: state `IDLE`, `wait_cnt` 0, `dbg_ack` 0, `dbg_rdata` 0, `stall_cnt` 0, `cpu_stall` 0, `mem_we` 0.
- Uncontended debug access: `req` seen in `IDLE` (cycle 0), `GRANT` in cycle 1, `dbg_ack` in cycle 2. Latency is 2 cycles.
- Contended debug access: worst-case `dbg_ack` at cycle `STARVE_LIMIT + 2` after request. At most one CPU stall cycle per debug transaction.
- A CPU access in the same cycle as `IDLE` with `dbg_req` is served with no stall. The CPU always wins outside `GRANT`.
- `cpu_stall` is combinational from `cpu_hit` and state. No combinational path from `dbg_*` to `cpu_stall`.
- Dropping `dbg_req` before `dbg_ack` is illegal. The transaction still completes.
- `RESET` asserted mid-transaction returns to `IDLE` immediately. No write is performed in that cycle and no `dbg_ack` is issued.
- Debug and CPU writing the same index: the debug write lands in `GRANT`, and the CPU store retires on the following unstalled cycle, so the CPU value persists.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (`IDLE`, `WAIT`, `GRANT`, `ACK`)
  - `DVAR_BASE = 0x800` and `DVAR_TOP = 0x9FC`
  - the index width 7
- Sub-module `dmem_addr_decode` (combinational `cpu_hit` and index). It is reused for the constant-memory decode.
- Everything else is flat in this block.

## Test plan
- Reset, then `dbg_req` write to index 5 with `0xDEADBEEF`, no CPU traffic. Expect `mem_we` in cycle 1, `dbg_ack` in cycle 2, and array[5] = `0xDEADBEEF`.
- `dbg_req` read of index 5 with no CPU traffic. Expect `dbg_ack` in cycle 2 with `dbg_rdata` = `0xDEADBEEF`, `stall_cnt` still 0.
- CPU stores to 0x800 every cycle and debug reads index 0, `STARVE_LIMIT` = 4. Expect 4 `WAIT` cycles, exactly one `cpu_stall` cycle, `dbg_ack` at cycle 6, `stall_cnt` = 1.
- CPU loads from 0x200 (constant range) every cycle with a debug write. Expect no stall and `dbg_ack` at cycle 2.
- `RESET` pulse during `GRANT` of a debug write of `0x12345678` to index 9. Expect array[9] unchanged, no `dbg_ack`, all outputs at reset values.
- Force `stall_cnt` near saturation (`CNT_W` = 4, 17 forced grants). Expect `stall_cnt` to hold at 15.
